ahb_subordinate_synth: RTL

- Synthesizable AHB-Lite subordinate: a small word-addressed memory that responds to a bus manager.
- Accepts NONSEQ/SEQ byte, halfword and word reads and writes.
- Inserts a configurable number of wait states.
- Returns the two-cycle ERROR response for illegal accesses.
- Intended as the peer of the synthesizable AHB manager test block, sitting on the same bus as the target at 0x1000.

---
 rtl/ahb_subordinate_synth.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ahb_subordinate_synth.sv
// ---------------------------------------------------------------------------
// ahb_subordinate_synth
//
// AHB-Lite subordinate wrapping a small word-addressed memory. Accepts
// NONSEQ/SEQ byte, halfword and word reads and writes. Every OKAY data phase
// is stretched by WAIT_STATES HREADYOUT-low cycles. Illegal accesses get the
// two-cycle ERROR response.
//
// Parameters:
//   BASE_ADDR   - first byte address decoded by this block
//   MEM_WORDS   - number of 32-bit memory words (power of two, >= 2)
//   WAIT_STATES - HREADYOUT-low cycles per OKAY data phase (0..15)
//
// Ports:
//   HCLK      in   bus clock, rising edge
//   HRESET    in   asynchronous active-high reset
//   HSEL      in   subordinate select
//   HADDR     in   [31:0] address-phase byte address
//   HTRANS    in   [1:0] transfer type (IDLE/BUSY/NONSEQ/SEQ)
//   HWRITE    in   1 = write, 0 = read
//   HSIZE     in   [2:0] byte / halfword / word
//   HWDATA    in   [31:0] write data (data phase)
//   HREADY    in   bus-wide ready
//   HREADYOUT out  this subordinate's ready
//   HRDATA    out  [31:0] read data (zero outside read data phases)
//   HRESP     out  0 OKAY, 1 ERROR
// ---------------------------------------------------------------------------
module ahb_subordinate_synth #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          MEM_WORDS   = 16,
  parameter int          WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP
);

  localparam int          IDX_W     = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN      = 32'(4 * MEM_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [3:0]        wait_cnt;
  logic [3:0]        wait_cnt_next;

  logic [31:0]       mem [MEM_WORDS];

  logic [IDX_W-1:0]  idx_q;
  logic [1:0]        lane_q;
  logic [1:0]        size_q;
  logic              write_q;

  logic [31:0]       offset;
  logic              active_trans;
  logic              can_accept;
  logic              accept;
  logic              illegal;
  logic [3:0]        byte_en;

  // Address-phase decode. The offset is an unsigned subtraction, so addresses
  // below BASE_ADDR wrap to huge values and fail the same range compare as
  // addresses beyond the top of memory.
  always_comb begin
    offset       = HADDR - BASE_ADDR;
    active_trans = (HTRANS == 2'b10) || (HTRANS == 2'b11);
    can_accept   = (state == ST_IDLE) || (state == ST_DATA) || (state == ST_ERR2);
    accept       = can_accept && HSEL && HREADY && active_trans;
    illegal      = (offset >= SPAN)
                || (HSIZE > 3'b010)
                || ((HSIZE == 3'b001) && HADDR[0])
                || ((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
  end

  // State and wait-counter register.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state logic and bus responses. Accepts are only honoured in states
  // that close a transfer with HREADYOUT high, so a pipelined address phase
  // is picked up on the same edge that completes the current data phase.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    HREADYOUT     = 1'b1;
    HRESP         = 1'b0;

    case (state)
      ST_WAIT: begin
        HREADYOUT     = 1'b0;
        wait_cnt_next = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) begin
          state_next = ST_DATA;
        end
      end
      ST_ERR1: begin
        HREADYOUT  = 1'b0;
        HRESP      = 1'b1;
        state_next = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP = 1'b1;
      end
      default: begin
      end
    endcase

    if (can_accept) begin
      if (accept) begin
        if (illegal) begin
          state_next = ST_ERR1;
        end else if (WAIT_INIT == 4'd0) begin
          state_next = ST_DATA;
        end else begin
          state_next    = ST_WAIT;
          wait_cnt_next = WAIT_INIT;
        end
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  // Address-phase capture. The word index is taken only from the in-range
  // offset bits, so no address outside the window aliases into memory.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      idx_q   <= '0;
      lane_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else if (accept && !illegal) begin
      idx_q   <= offset[IDX_W+1:2];
      lane_q  <= HADDR[1:0];
      size_q  <= HSIZE[1:0];
      write_q <= HWRITE;
    end
  end

  // Byte-lane enables for writes, little-endian: lane a carries HWDATA[8a+7:8a].
  always_comb begin
    byte_en = 4'b0000;
    case (size_q)
      2'b00:   byte_en = 4'b0001 << lane_q;
      2'b01:   byte_en = 4'b0011 << lane_q;
      default: byte_en = 4'b1111;
    endcase
  end

  // Memory array. Writes commit on the closing edge of the DATA cycle, which
  // is why a read pipelined right behind a write already sees the new data.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < MEM_WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if ((state == ST_DATA) && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

  // Read data is the whole addressed word, unshifted; zero in every other cycle.
  always_comb begin
    HRDATA = 32'h0;
    if ((state == ST_DATA) && !write_q) begin
      HRDATA = mem[idx_q];
    end
  end

endmodule
